// File: rtl/prio_encoder_8_3.sv
// prio_encoder_8_3: sequential 8-to-3 request encoder.
// Captures an 8-bit request vector and hands out the index of each set bit,
// lowest first, one per valid/ready handshake. Every output is decoded from
// registers only, so load/in/ready never reach an output combinationally.
module prio_encoder_8_3 (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] in,
   input  logic       ready,
   output logic [2:0] out,
   output logic       valid,
   output logic       busy,
   output logic [7:0] pending,
   output logic [3:0] count,
   output logic       done
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t     state, state_nxt;
   logic [7:0] pending_nxt;
   logic       done_nxt;
   logic [2:0] low_idx;
   logic [7:0] low_hot;

   // Lowest set bit of the registered mask, bit 0 has highest priority.
   // Scanning downward lets the lowest set bit win the last assignment.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending[i]) low_idx = 3'(i);
      end
      low_hot = 8'd1 << low_idx;
   end

   // Population count of the registered mask.
   always_comb begin
      count = 4'd0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'd0, pending[i]};
      end
   end

   // Outputs decoded from state and mask; out is forced to 0 when not valid.
   always_comb begin
      valid = (state == DRAIN);
      busy  = (state == DRAIN);
      out   = (state == DRAIN) ? low_idx : 3'd0;
   end

   // Next-state logic: capture in IDLE, retire one bit per handshake in DRAIN.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            // An all-zero vector has nothing to drain, so it is dropped.
            if (load && (in != 8'd0)) begin
               pending_nxt = in;
               state_nxt   = DRAIN;
            end
         end
         DRAIN: begin
            if (ready) begin
               pending_nxt = pending & ~low_hot;
               if ((pending & ~low_hot) == 8'd0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            state_nxt   = IDLE;
            pending_nxt = 8'd0;
         end
      endcase
   end

   // State, mask and done-pulse registers; reset discards outstanding requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= 8'd0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_prio_encoder_8_3.sv
// Testbench for prio_encoder_8_3: directed scenarios plus randomized vectors
// and ready patterns, checked by a queue-based reference model.
module tb_prio_encoder_8_3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] in = 8'd0;
   logic       ready = 1'b0;
   logic [2:0] out;
   logic       valid;
   logic       busy;
   logic [7:0] pending;
   logic [3:0] count;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Reference model: indices still owed for the current vector, lowest first.
   int q[$];
   bit done_exp = 1'b0;

   prio_encoder_8_3 dut (
      .clk(clk), .rst(rst), .load(load), .in(in), .ready(ready),
      .out(out), .valid(valid), .busy(busy), .pending(pending),
      .count(count), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then return just after the sampling edge.
   task automatic step(input bit l, input logic [7:0] v, input bit r);
      load  = l;
      in    = v;
      ready = r;
      @(posedge clk);
      #1;
   endtask

   function automatic int q_mask();
      int m = 0;
      foreach (q[i]) m += (1 << q[i]);
      return m;
   endfunction

   // Monitor: compare DUT outputs against the model mid-cycle, then advance
   // the model by what the coming edge will do with the current inputs.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", valid, 0);
         chk("rst_pending", pending, 0);
         chk("rst_done", done, 0);
         q.delete();
         done_exp = 1'b0;
      end else begin
         chk("valid", valid, (q.size() != 0));
         chk("busy", busy, (q.size() != 0));
         chk("count", count, q.size());
         chk("pending", pending, q_mask());
         chk("out", out, (q.size() != 0) ? q[0] : 0);
         chk("done", done, done_exp);
         done_exp = 1'b0;
         if (q.size() == 0) begin
            if (load && in != 8'd0)
               for (int i = 0; i < 8; i++)
                  if ((in >> i) & 1) q.push_back(i);
         end else if (ready) begin
            void'(q.pop_front());
            if (q.size() == 0) done_exp = 1'b1;
         end
      end
   end

   initial begin
      int idle_cnt;
      #1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Zero vector is ignored.
      step(1, 8'h00, 1);
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);

      // Basic drain with ready held.
      step(1, 8'hA5, 1);
      repeat (6) step(0, 8'h00, 1);

      // Backpressure.
      step(1, 8'h12, 0);
      repeat (3) step(0, 8'h00, 0);
      repeat (3) step(0, 8'h00, 1);

      // Load while draining is ignored.
      step(1, 8'h81, 1);
      step(1, 8'hFF, 1);
      repeat (3) step(0, 8'h00, 1);

      // Back-to-back: load in the done cycle.
      step(1, 8'h01, 1);
      step(0, 8'h00, 1);
      step(1, 8'h40, 1);
      repeat (3) step(0, 8'h00, 1);

      // Full vector.
      step(1, 8'hFF, 1);
      repeat (10) step(0, 8'h00, 1);

      // Reset mid-drain, checked immediately (asynchronous).
      step(1, 8'hF0, 1);
      step(0, 8'h00, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_valid", valid, 0);
      chk("async_busy", busy, 0);
      chk("async_out", out, 0);
      chk("async_pending", pending, 0);
      chk("async_count", count, 0);
      chk("async_done", done, 0);
      step(0, 8'h00, 0);
      rst = 1'b0;
      step(0, 8'h00, 1);
      step(1, 8'h08, 1);
      repeat (3) step(0, 8'h00, 1);

      // Random vectors and random backpressure.
      for (int n = 0; n < 400; n++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         step($urandom_range(0, 2) == 0, v, $urandom_range(0, 9) < 7);
      end

      // Drain with a bounded cycle budget; an expired bound counts as a failure.
      idle_cnt = 0;
      while (q.size() != 0 && idle_cnt < 20) begin
         step(0, 8'h00, 1);
         idle_cnt++;
      end
      chk("drain_timeout", q.size(), 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
